// File: rtl/keccak_state_serializer.sv
// Captures a 5x5x64 Keccak state, packs it into the 1600-bit FIPS 202 string
// and streams it out lane by lane over a valid/ready handshake.
module keccak_state_serializer #(
  parameter int LANE_W        = 64,
  parameter int NUM_LANES_MAX = 25
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [4:0][4:0][LANE_W-1:0]       A_in,
  input  logic                              start,
  input  logic [4:0]                        num_lanes,
  input  logic                              abort,
  output logic [NUM_LANES_MAX*LANE_W-1:0]   S_out,
  output logic [LANE_W-1:0]                 lane_out,
  output logic [4:0]                        lane_idx,
  output logic                              lane_valid,
  input  logic                              lane_ready,
  output logic                              lane_last,
  output logic                              busy,
  output logic                              done
);

  localparam int S_W = NUM_LANES_MAX * LANE_W;

  typedef enum logic [1:0] {IDLE, LOAD, SEND, DONE} state_t;

  state_t              state_reg, state_next;
  logic [S_W-1:0]      s_reg, s_next, s_pack;
  logic [LANE_W-1:0]   lane_reg, lane_next;
  logic [4:0]          idx_reg, idx_next, idx_inc;
  logic [4:0]          cnt_reg, cnt_next;
  logic                valid_reg, valid_next;
  logic                last_reg, last_next;

  // Lane (x,y) lands at string index i = 5*y + x, bits kept in natural order.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_LANES_MAX; gi++) begin : g_pack
      assign s_pack[gi*LANE_W +: LANE_W] = A_in[gi % 5][gi / 5];
    end
  endgenerate

  assign idx_inc = idx_reg + 5'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      s_reg     <= '0;
      lane_reg  <= '0;
      idx_reg   <= '0;
      cnt_reg   <= '0;
      valid_reg <= 1'b0;
      last_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      s_reg     <= s_next;
      lane_reg  <= lane_next;
      idx_reg   <= idx_next;
      cnt_reg   <= cnt_next;
      valid_reg <= valid_next;
      last_reg  <= last_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    s_next     = s_reg;
    lane_next  = lane_reg;
    idx_next   = idx_reg;
    cnt_next   = cnt_reg;
    valid_next = valid_reg;
    last_next  = last_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          s_next     = s_pack;
          cnt_next   = (num_lanes == 5'd0 || num_lanes > 5'(NUM_LANES_MAX))
                       ? 5'(NUM_LANES_MAX) : num_lanes;
          state_next = LOAD;
        end
      end
      LOAD: begin
        if (abort) begin
          state_next = IDLE;
        end else begin
          idx_next   = 5'd0;
          lane_next  = s_reg[LANE_W-1:0];
          valid_next = 1'b1;
          last_next  = (cnt_reg == 5'd1);
          state_next = SEND;
        end
      end
      SEND: begin
        // Abort outranks a beat that would otherwise transfer on this edge.
        if (abort) begin
          valid_next = 1'b0;
          last_next  = 1'b0;
          state_next = IDLE;
        end else if (valid_reg && lane_ready) begin
          if (last_reg) begin
            valid_next = 1'b0;
            last_next  = 1'b0;
            state_next = DONE;
          end else begin
            idx_next  = idx_inc;
            lane_next = s_reg[int'(idx_inc)*LANE_W +: LANE_W];
            last_next = (idx_inc == cnt_reg - 5'd1);
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign S_out      = s_reg;
  assign lane_out   = lane_reg;
  assign lane_idx   = idx_reg;
  assign lane_valid = valid_reg;
  assign lane_last  = last_reg;
  assign busy       = (state_reg == LOAD) || (state_reg == SEND);
  assign done       = (state_reg == DONE);

endmodule
